sample_capture_buffer: RTL and testbench

Parametrised capture buffer that follows the ADC sampler and feeds the EEPROM/I2C writer. Once armed, it accepts one sample per clock until DEPTH words are stored, then drains them in order on read requests with a fixed 1-cycle read latency. It returns to idle on `rearm` without a power cycle, so repeated capture frames are supported. Width and depth are configurable, and the default matches the 8-bit × 256 frame used today.

---
 rtl/sample_capture_pkg.sv | 27 ++
 rtl/sample_capture_ram.sv | 42 ++++
 rtl/sample_capture_buffer.sv | 139 +++++++++++++
 tb/tb_sample_capture_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_capture_pkg.sv
// Shared definitions for the sample capture buffer.
// This package holds the capture FSM state encoding and the address-width helper.
// It also holds the frame encoding constants that the EEPROM/I2C writer shares.
package sample_capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_FILL = 2'd1,
    CAP_FULL = 2'd2,
    CAP_DONE = 2'd3
  } capture_state_e;

  // Frame markers and device address used by the EEPROM writer downstream.
  localparam logic [7:0] EE_FRAME_SOF = 8'hA5;
  localparam logic [7:0] EE_FRAME_EOF = 8'h5A;
  localparam logic [6:0] EE_DEV_ADDR  = 7'h50;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    if (depth <= 2) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port RAM for the capture buffer, WIDTH x DEPTH.
// It has one write port and one registered read port with 1-cycle latency.
// The read register resets to zero and holds its value when no read is issued.
module sample_capture_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: storage is never cleared, only overwritten.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port: the word appears in the cycle after the request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sample_capture_buffer.sv
// Capture buffer: once armed it fills DEPTH samples, then drains them in order.
// When define SAMPLE_CAPTURE_OVERRUN_EN is set, the block counts writes that are
// dropped while the frame waits to drain, and the o_overrun_cnt port appears.
module sample_capture_buffer
  import sample_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int OVR_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_mem_en,
  input  logic                       i_rearm,
  input  logic                       i_write_en,
  input  logic [WIDTH-1:0]           i_data_in,
  input  logic                       i_read_en,
  output logic [WIDTH-1:0]           o_data_out,
  output logic                       o_data_valid,
  output logic                       o_is_full,
  output logic                       o_done,
  output logic [$clog2(DEPTH+1)-1:0] o_level
`ifdef SAMPLE_CAPTURE_OVERRUN_EN
  ,
  output logic [OVR_W-1:0]           o_overrun_cnt
`endif
);

  localparam int AW = addr_w(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  if (DEPTH < 2 || OVR_W < 1) begin : g_cfg_check
    $error("sample_capture_buffer: DEPTH must be >= 2 and OVR_W >= 1");
  end

  capture_state_e r_state;
  capture_state_e w_state_nxt;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic           w_wr_acc;
  logic           w_rd_acc;

  // rearm outranks any transfer in the same cycle, so a rearm cycle never touches the RAM.
  assign w_wr_acc = i_write_en && (r_state == CAP_FILL) && !i_rearm;
  assign w_rd_acc = i_read_en && (r_state == CAP_FULL) && (r_level != '0) && !i_rearm;

  // Next-state decode for the capture frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CAP_IDLE: begin
        if (i_mem_en) w_state_nxt = CAP_FILL;
        else          w_state_nxt = CAP_IDLE;
      end
      CAP_FILL: begin
        if (w_wr_acc && (r_level == LW'(DEPTH-1))) w_state_nxt = CAP_FULL;
        else                                       w_state_nxt = CAP_FILL;
      end
      CAP_FULL: begin
        if (w_rd_acc && (r_level == LW'(1))) w_state_nxt = CAP_DONE;
        else                                 w_state_nxt = CAP_FULL;
      end
      CAP_DONE: w_state_nxt = CAP_DONE;
      default:  w_state_nxt = CAP_IDLE;
    endcase
  end

  // State, pointers, level and status flags; the flags are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_rearm) begin
      r_state      <= CAP_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      o_is_full    <= 1'b0;
      o_done       <= 1'b0;
      o_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      o_is_full    <= (w_state_nxt == CAP_FULL);
      o_done       <= (w_state_nxt == CAP_DONE);
      o_data_valid <= w_rd_acc;
      if (r_state == CAP_IDLE) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + AW'(1);
        end
        if (w_rd_acc) begin
          r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + AW'(1);
        end
      end
      if (w_wr_acc) begin
        r_level <= r_level + LW'(1);
      end else if (w_rd_acc) begin
        r_level <= r_level - LW'(1);
      end else begin
        r_level <= r_level;
      end
    end
  end

  assign o_level = r_level;

`ifdef SAMPLE_CAPTURE_OVERRUN_EN
  logic [OVR_W-1:0] r_overrun_cnt;

  // Count samples lost while a full frame waits to drain; saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_rearm) begin
      r_overrun_cnt <= '0;
    end else if (i_write_en && (r_state == CAP_FULL) && (r_overrun_cnt != '1)) begin
      r_overrun_cnt <= r_overrun_cnt + OVR_W'(1);
    end else begin
      r_overrun_cnt <= r_overrun_cnt;
    end
  end

  assign o_overrun_cnt = r_overrun_cnt;
`endif

  sample_capture_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_data_out)
  );

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Testbench for sample_capture_buffer: a default 8x256 instance and a 12x4 instance.
// Expected values come from a queue-based frame model that is stepped every clock.
module tb_sample_capture_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (WIDTH=8, DEPTH=256).
  logic       b_rst, b_men, b_rearm, b_we, b_re;
  logic [7:0] b_din, b_dout;
  logic       b_dv, b_full, b_done;
  logic [8:0] b_level;
  // Small instance (WIDTH=12, DEPTH=4).
  logic        s_rst, s_men, s_rearm, s_we, s_re;
  logic [11:0] s_din, s_dout;
  logic        s_dv, s_full, s_done;
  logic [2:0]  s_level;
`ifdef SAMPLE_CAPTURE_OVERRUN_EN
  logic [7:0] b_ovr, s_ovr;
`endif

  wire [31:0] b_obs = {12'd0, b_full, b_done, b_dv, b_level, b_dout};
  wire [31:0] s_obs = {14'd0, s_full, s_done, s_dv, s_level, s_dout};

  sample_capture_buffer u_big (
    .i_clk(clk), .i_rst(b_rst), .i_mem_en(b_men), .i_rearm(b_rearm),
    .i_write_en(b_we), .i_data_in(b_din), .i_read_en(b_re),
    .o_data_out(b_dout), .o_data_valid(b_dv), .o_is_full(b_full),
    .o_done(b_done), .o_level(b_level)
`ifdef SAMPLE_CAPTURE_OVERRUN_EN
    , .o_overrun_cnt(b_ovr)
`endif
  );

  sample_capture_buffer #(.WIDTH(12), .DEPTH(4), .OVR_W(8)) u_small (
    .i_clk(clk), .i_rst(s_rst), .i_mem_en(s_men), .i_rearm(s_rearm),
    .i_write_en(s_we), .i_data_in(s_din), .i_read_en(s_re),
    .o_data_out(s_dout), .o_data_valid(s_dv), .o_is_full(s_full),
    .o_done(s_done), .o_level(s_level)
`ifdef SAMPLE_CAPTURE_OVERRUN_EN
    , .o_overrun_cnt(s_ovr)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phase 0 idle, 1 filling, 2 full, 3 drained; queue holds unread words.
  int          m_phase [2];
  int          m_wcnt  [2];
  logic [31:0] m_dout  [2];
  bit          m_dv    [2];
  int          m_ovr   [2];
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  function automatic int qsize(input int id);
    if (id == 0) return q0.size();
    else         return q1.size();
  endfunction

  task automatic qpush(input int id, input logic [31:0] v);
    if (id == 0) q0.push_back(v);
    else         q1.push_back(v);
  endtask

  task automatic qpop(input int id, output logic [31:0] v);
    if (id == 0) v = q0.pop_front();
    else         v = q1.pop_front();
  endtask

  task automatic qclear(input int id);
    if (id == 0) q0.delete();
    else         q1.delete();
  endtask

  task automatic model_upd(input int id, input bit rst, input bit rearm, input bit men,
                           input bit we, input bit re, input logic [31:0] din);
    int          dep;
    logic [31:0] msk;
    logic [31:0] v;
    dep = (id == 0) ? 256 : 4;
    msk = (id == 0) ? 32'hFF : 32'hFFF;
    if (rst) begin
      m_phase[id] = 0; qclear(id); m_wcnt[id] = 0;
      m_dout[id] = 0; m_dv[id] = 0; m_ovr[id] = 0;
    end else if (rearm) begin
      m_phase[id] = 0; qclear(id); m_wcnt[id] = 0;
      m_dv[id] = 0; m_ovr[id] = 0;
    end else begin
      m_dv[id] = 0;
      case (m_phase[id])
        0: if (men) begin m_phase[id] = 1; m_wcnt[id] = 0; end
        1: if (we) begin
             qpush(id, din & msk);
             m_wcnt[id]++;
             if (m_wcnt[id] == dep) m_phase[id] = 2;
           end
        2: begin
             if (we && m_ovr[id] < 255) m_ovr[id]++;
             if (re) begin
               qpop(id, v);
               m_dout[id] = v;
               m_dv[id] = 1;
               if (qsize(id) == 0) m_phase[id] = 3;
             end
           end
        default: ;
      endcase
    end
  endtask

  // Expected {is_full, done, data_valid, level, data_out} packed like b_obs / s_obs.
  function automatic logic [31:0] exp_vec(input int id);
    int lw, dw;
    logic [31:0] v;
    lw = (id == 0) ? 9 : 3;
    dw = (id == 0) ? 8 : 12;
    v = m_dout[id];
    v = v | (32'(qsize(id)) << dw);
    v = v | (32'(m_dv[id]) << (dw + lw));
    v = v | (32'(m_phase[id] == 3) << (dw + lw + 1));
    v = v | (32'(m_phase[id] == 2) << (dw + lw + 2));
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_upd(0, b_rst, b_rearm, b_men, b_we, b_re, {24'd0, b_din});
    model_upd(1, s_rst, s_rearm, s_men, s_we, s_re, {20'd0, s_din});
  endtask

  task automatic test_reset();
    b_rst = 1'b1; s_rst = 1'b1;
    step(); step();
    n_chk++;
    if (b_obs !== 32'd0) $display("FAIL reset_big obs=%h exp=%h", b_obs, 32'd0);
    else n_pass++;
    n_chk++;
    if (s_obs !== 32'd0) $display("FAIL reset_small obs=%h exp=%h", s_obs, 32'd0);
    else n_pass++;
`ifdef SAMPLE_CAPTURE_OVERRUN_EN
    n_chk++;
    if (b_ovr !== 8'd0) $display("FAIL reset_ovr obs=%0d exp=0", b_ovr);
    else n_pass++;
`endif
    b_rst = 1'b0; s_rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    int first_full;
    first_full = 0;
    b_men = 1'b1; step();
    for (int i = 0; i < 256; i++) begin
      b_we = 1'b1; b_din = 8'(i); b_men = 1'($urandom_range(1, 0));
      b_re = 1'($urandom_range(1, 0));
      step();
      if (b_full && first_full == 0) first_full = i + 1;
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL fill[%0d] obs=%h exp=%h", i, b_obs, exp_vec(0));
      else n_pass++;
    end
    b_we = 1'b0; b_men = 1'b0; b_re = 1'b0;
    n_chk++;
    if (first_full !== 256) $display("FAIL fill_latency obs=%0d exp=256", first_full);
    else n_pass++;
    n_chk++;
    if (b_level !== 9'd256) $display("FAIL fill_level obs=%0d exp=256", b_level);
    else n_pass++;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) begin
      b_we = 1'b1; b_din = 8'hAA;
      step();
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL overrun[%0d] obs=%h exp=%h", i, b_obs, exp_vec(0));
      else n_pass++;
    end
    b_we = 1'b0;
`ifdef SAMPLE_CAPTURE_OVERRUN_EN
    n_chk++;
    if (32'(b_ovr) !== 32'(m_ovr[0])) $display("FAIL overrun_cnt obs=%0d exp=%0d", b_ovr, m_ovr[0]);
    else n_pass++;
`endif
  endtask

  task automatic test_drain();
    bit done_seen;
    done_seen = 0;
    for (int i = 0; i < 256; i++) begin
      b_re = 1'b1;
      step();
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL drain[%0d] obs=%h exp=%h", i, b_obs, exp_vec(0));
      else n_pass++;
      if (b_done && !done_seen) begin
        done_seen = 1;
        n_chk++;
        if (b_dout !== 8'hFF || b_dv !== 1'b1 || i != 255)
          $display("FAIL done_align obs=dout %h dv %b at %0d exp=dout ff dv 1 at 255", b_dout, b_dv, i);
        else n_pass++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      b_re = 1'($urandom_range(1, 0));
      step();
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL after_done[%0d] obs=%h exp=%h", i, b_obs, exp_vec(0));
      else n_pass++;
    end
    b_re = 1'b0;
  endtask

  task automatic test_rearm_midfill();
    int n;
    b_rearm = 1'b1; step(); b_rearm = 1'b0;
    b_men = 1'b1; step(); b_men = 1'b0;
    for (int i = 0; i < 100; i++) begin
      b_we = 1'b1; b_din = 8'($urandom); b_re = 1'($urandom_range(1, 0));
      step();
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL part_fill[%0d] obs=%h exp=%h", i, b_obs, exp_vec(0));
      else n_pass++;
    end
    b_rearm = 1'b1; b_we = 1'b1; b_re = 1'b0;
    step();
    b_rearm = 1'b0; b_we = 1'b0;
    n_chk++;
    if (b_level !== 9'd0 || b_full !== 1'b0) $display("FAIL rearm_clear obs=level %0d full %b exp=level 0 full 0", b_level, b_full);
    else n_pass++;
    b_men = 1'b1; step(); b_men = 1'b0;
    n = 0;
    while (n < 3000 && m_phase[0] != 3) begin
      b_we = ($urandom_range(3, 0) != 0); b_din = 8'($urandom);
      b_re = ($urandom_range(3, 0) != 0);
      step();
      n++;
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL refill[%0d] obs=%h exp=%h", n, b_obs, exp_vec(0));
      else n_pass++;
    end
    b_we = 1'b0; b_re = 1'b0;
    n_chk++;
    if (b_done !== 1'b1) $display("FAIL refill_done obs=%b exp=1 within budget", b_done);
    else n_pass++;
  endtask

  task automatic test_rst_drain();
    b_rearm = 1'b1; step(); b_rearm = 1'b0;
    b_men = 1'b1; step(); b_men = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b_we = 1'b1; b_din = 8'($urandom); step();
    end
    b_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_re = 1'b1; step();
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL pre_rst_read[%0d] obs=%h exp=%h", i, b_obs, exp_vec(0));
      else n_pass++;
    end
    b_rst = 1'b1; step(); b_rst = 1'b0;
    n_chk++;
    if (b_obs !== 32'd0) $display("FAIL rst_drain obs=%h exp=%h", b_obs, 32'd0);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      b_re = 1'b1; step();
      n_chk++;
      if (b_obs !== exp_vec(0)) $display("FAIL rst_read_ignored[%0d] obs=%h exp=%h", i, b_obs, exp_vec(0));
      else n_pass++;
    end
    b_re = 1'b0;
  endtask

  task automatic test_small_concurrent();
    int n;
    for (int f = 0; f < 3; f++) begin
      s_rearm = 1'b1; step(); s_rearm = 1'b0;
      s_men = 1'b1; step(); s_men = 1'b0;
      n = 0;
      while (n < 200 && m_phase[1] != 3) begin
        s_we = 1'($urandom_range(1, 0)); s_re = 1'($urandom_range(1, 0));
        s_din = 12'($urandom);
        step();
        n++;
        n_chk++;
        if (s_obs !== exp_vec(1)) $display("FAIL small_f%0d[%0d] obs=%h exp=%h", f, n, s_obs, exp_vec(1));
        else n_pass++;
      end
      s_we = 1'b0; s_re = 1'b0;
      n_chk++;
      if (s_done !== 1'b1) $display("FAIL small_done_f%0d obs=%b exp=1 within budget", f, s_done);
      else n_pass++;
    end
    // A read one edge before rearm still delivers its valid pulse; data_out survives rearm.
    s_rearm = 1'b1; step(); s_rearm = 1'b0;
    s_men = 1'b1; step(); s_men = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_we = 1'b1; s_din = 12'($urandom); step();
    end
    s_we = 1'b0;
    s_re = 1'b1; step(); s_re = 1'b0;
    n_chk++;
    if (s_obs !== exp_vec(1)) $display("FAIL small_read_before_rearm obs=%h exp=%h", s_obs, exp_vec(1));
    else n_pass++;
    s_rearm = 1'b1; s_re = 1'b1; step(); s_rearm = 1'b0; s_re = 1'b0;
    n_chk++;
    if (s_obs !== exp_vec(1)) $display("FAIL small_rearm_hold obs=%h exp=%h", s_obs, exp_vec(1));
    else n_pass++;
  endtask

  initial begin
    b_rst = 1'b1; b_men = 1'b0; b_rearm = 1'b0; b_we = 1'b0; b_re = 1'b0; b_din = 8'd0;
    s_rst = 1'b1; s_men = 1'b0; s_rearm = 1'b0; s_we = 1'b0; s_re = 1'b0; s_din = 12'd0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_wcnt[i] = 0; m_dout[i] = 0; m_dv[i] = 0; m_ovr[i] = 0;
    end
    test_reset();
    test_fill();
    test_overrun();
    test_drain();
    test_rearm_midfill();
    test_rst_drain();
    test_small_concurrent();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
